// File: rtl/program_loader_if.sv
// Stream and memory-write bus for the program loader.
//   in_valid/in_data/in_ready        : byte stream from the host link
//   ext_mem_wen/addr/data            : write port into the CPU's memory
// master: host side (drives the stream, observes the write port)
// slave : the loader
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ext_mem_wen;
  logic [ADDR_W-1:0] ext_mem_addr;
  logic [DATA_W-1:0] ext_mem_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, ext_mem_wen, ext_mem_addr, ext_mem_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ext_mem_wen, ext_mem_addr, ext_mem_data
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader. Receives a frame
//   base address, word count (0 = 256), N x {hi, lo}, XOR checksum
// and writes each word into CPU memory through the external write port,
// holding the CPU while loading and releasing it after a clean load.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, begins a load when idle
//   abort       : cancels a load in progress (sets err)
//   bus         : stream handshake + memory write port (slave modport)
//   cpu_hold    : holds the CPU in reset/stall
//   busy        : load in progress
//   done        : one-cycle pulse at end of load
//   err         : sticky checksum/abort error, cleared by next start
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  program_loader_if.slave   bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, HDR_ADDR, HDR_LEN, DATA_HI, DATA_LO, WRITE, CHECK, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        cnt_q;
  logic [7:0]        hi_q;
  logic [7:0]        csum_q;
  logic              cpu_hold_q, busy_q, done_q, err_q;
  logic              xfer;
  logic              abort_act;

  assign xfer      = bus.in_valid & in_ready_q;
  assign abort_act = abort & (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = HDR_ADDR;
      HDR_ADDR: if (xfer)  state_d = HDR_LEN;
      HDR_LEN:  if (xfer)  state_d = DATA_HI;
      DATA_HI:  if (xfer)  state_d = DATA_LO;
      DATA_LO:  if (xfer)  state_d = WRITE;
      WRITE:    state_d = (cnt_q == 9'd1) ? CHECK : DATA_HI;
      CHECK:    if (xfer)  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // in_ready depends only on state; derive it from the next state so it
      // is already valid in the first cycle of each accepting state.
      in_ready_q <= (state_d inside {HDR_ADDR, HDR_LEN, DATA_HI, DATA_LO, CHECK});
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      if (abort_act) begin
        err_q      <= 1'b1;
        busy_q     <= 1'b0;
        cpu_hold_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: if (start) begin
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            err_q      <= 1'b0;
            csum_q     <= '0;
          end
          HDR_ADDR: if (xfer) addr_q <= ADDR_W'(bus.in_data);
          HDR_LEN:  if (xfer) cnt_q  <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          DATA_HI: if (xfer) begin
            hi_q   <= bus.in_data;
            csum_q <= csum_q ^ bus.in_data;
          end
          // The strobe is launched here so it is high exactly during WRITE.
          DATA_LO: if (xfer) begin
            wen_q      <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= DATA_W'({hi_q, bus.in_data});
            csum_q     <= csum_q ^ bus.in_data;
          end
          WRITE: begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - 9'd1;
          end
          CHECK: if (xfer) begin
            err_q  <= (bus.in_data != csum_q);
            done_q <= 1'b1;
          end
          DONE: begin
            busy_q     <= 1'b0;
            cpu_hold_q <= err_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.ext_mem_wen  = wen_q;
  assign bus.ext_mem_addr = mem_addr_q;
  assign bus.ext_mem_data = mem_data_q;
  assign cpu_hold         = cpu_hold_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames, a write-list
// scoreboard built from each frame, and literal checks on key results.
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cpu_hold, busy, done, err;

  program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int dones = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] act_addr[$];
  logic [DATA_W-1:0] act_data[$];
  logic [15:0] word_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next expected write in order.
  always @(negedge clk) begin
    if (rst_n && bus.ext_mem_wen) begin
      strobes++;
      act_addr.push_back(bus.ext_mem_addr);
      act_data.push_back(bus.ext_mem_data);
      check("in_ready_during_write", 32'(bus.in_ready), 32'd0);
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.ext_mem_addr, bus.ext_mem_data);
      end else begin
        check("wr_addr", 32'(bus.ext_mem_addr), 32'(exp_addr.pop_front()));
        check("wr_data", 32'(bus.ext_mem_data), 32'(exp_data.pop_front()));
      end
    end
    if (rst_n && done) dones++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    bus.in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (!bus.in_ready && guard <= 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard > 20) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got ready=0, expected ready=1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int gap_for(input logic bp);
    return bp ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic run_frame(input logic [7:0] base, input logic [7:0] nbyte,
                           input logic bad, input logic bp, output logic [7:0] csum_o);
    int n, s0, d0;
    logic [7:0] csum;
    logic [15:0] w;
    n = (nbyte == 8'd0) ? 256 : int'(nbyte);
    csum = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = word_mem[i];
      csum ^= w[15:8] ^ w[7:0];
      exp_addr.push_back(8'(int'(base) + i));
      exp_data.push_back(w);
    end
    csum_o = csum;
    s0 = strobes;
    d0 = dones;
    pulse_start();
    check("err_after_start", 32'(err), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    send_byte(base, gap_for(bp));
    send_byte(nbyte, gap_for(bp));
    for (int i = 0; i < n; i++) begin
      w = word_mem[i];
      send_byte(w[15:8], gap_for(bp));
      send_byte(w[7:0], gap_for(bp));
    end
    send_byte(bad ? 8'h00 : csum, gap_for(bp));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("err_after_done", 32'(err), 32'(bad));
    check("hold_after_done", 32'(cpu_hold), 32'(bad));
    check("strobe_count", 32'(strobes - s0), 32'(n));
    check("done_count", 32'(dones - d0), 32'd1);
    check("writes_pending", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic load_basic_words();
    word_mem[0] = 16'h0801;
    word_mem[1] = 16'h3C05;
  endtask

  initial begin
    logic [7:0] cs;
    int s0, d0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_wen", 32'(bus.ext_mem_wen), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.in_ready), 32'd0);

    // Basic load; the data bytes XOR to 0x30
    load_basic_words();
    act_addr.delete();
    act_data.delete();
    run_frame(8'h10, 8'h02, 1'b0, 1'b0, cs);
    check("model_csum", 32'(cs), 32'h30);
    check("basic_addr0", 32'(act_addr[0]), 32'h10);
    check("basic_data0", 32'(act_data[0]), 32'h0801);
    check("basic_addr1", 32'(act_addr[1]), 32'h11);
    check("basic_data1", 32'(act_data[1]), 32'h3C05);

    // Wrap with N = 0 (256 words)
    for (int i = 0; i < 256; i++) word_mem[i] = 16'(i * 257) ^ 16'h1234;
    act_addr.delete();
    act_data.delete();
    run_frame(8'hFF, 8'h00, 1'b0, 1'b0, cs);
    check("wrap_count", 32'(act_addr.size()), 32'd256);
    check("wrap_first", 32'(act_addr[0]), 32'hFF);
    check("wrap_second", 32'(act_addr[1]), 32'h00);
    check("wrap_last", 32'(act_addr[255]), 32'hFE);

    // Backpressure: random gaps, same writes
    load_basic_words();
    act_addr.delete();
    act_data.delete();
    run_frame(8'h10, 8'h02, 1'b0, 1'b1, cs);
    check("bp_data1", 32'(act_data[1]), 32'h3C05);

    // Checksum error: writes still land, CPU stays held
    run_frame(8'h10, 8'h02, 1'b1, 1'b0, cs);

    // Abort in DATA_HI of word 2
    s0 = strobes;
    d0 = dones;
    exp_addr.push_back(8'h20);
    exp_data.push_back(16'h1234);
    pulse_start();
    send_byte(8'h20, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("abort_wen_in_write", 32'(bus.ext_mem_wen), 32'd1);
    @(negedge clk);
    check("abort_ready_data_hi", 32'(bus.in_ready), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_err", 32'(err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd1);
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_strobes", 32'(strobes - s0), 32'd1);
    check("abort_no_done", 32'(dones - d0), 32'd0);
    check("abort_pending", 32'(exp_addr.size()), 32'd0);
    // Next start clears err (checked inside run_frame)
    run_frame(8'h10, 8'h02, 1'b0, 1'b0, cs);

    // Reset asserted during WRITE
    exp_addr.push_back(8'h40);
    exp_data.push_back(16'hABCD);
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    check("rstmid_wen_before", 32'(bus.ext_mem_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_wen", 32'(bus.ext_mem_wen), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_hold", 32'(cpu_hold), 32'd1);
    check("rstmid_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_pending", 32'(exp_addr.size()), 32'd0);
    run_frame(8'h10, 8'h02, 1'b0, 1'b0, cs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
